// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared constants, FSM encoding and golden arithmetic for the sweep checker
package au_pkg;

  localparam logic AU_SEL_ADD = 1'b0;
  localparam logic AU_SEL_MUL = 1'b1;
  localparam int   AU_VEC_W   = 5;
  localparam int   AU_Y_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } au_state_e;

  // Operands are widened before the op so 3*3 and 3+3 do not wrap.
  function automatic logic [AU_Y_W-1:0] au_golden(
    input logic [1:0] op_a,
    input logic [1:0] op_b,
    input logic       op_sel
  );
    logic [AU_Y_W-1:0] ea;
    logic [AU_Y_W-1:0] eb;
    ea = {2'b00, op_a};
    eb = {2'b00, op_b};
    return (op_sel == AU_SEL_MUL) ? ea * eb : ea + eb;
  endfunction

endpackage

// File: rtl/au_ref_model.sv
// rtl/au_ref_model.sv - combinational expected result of the arithmetic unit
module au_ref_model
  import au_pkg::*;
(
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  input  logic              sel,
  output logic [AU_Y_W-1:0] y
);

  assign y = au_golden(a, b, sel);

endmodule

// File: rtl/au_sweep_checker.sv
// rtl/au_sweep_checker.sv - drives all 32 operand/op vectors into the arithmetic unit and checks y
module au_sweep_checker
  import au_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] y,
  output logic [1:0] a,
  output logic [1:0] b,
  output logic       sel,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_seen,
  output logic [4:0] first_fail_idx
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  au_state_e             state;
  au_state_e             next_state;
  logic [AU_VEC_W-1:0]   idx;
  logic [3:0]            cnt;
  logic [AU_Y_W-1:0]     expected;
  logic                  start_acc;
  logic                  sample;
  logic                  mismatch;
  logic                  last_vec;
  logic [5:0]            err_next;

  // The vector index is the single source of the operand outputs.
  assign a   = idx[4:3];
  assign b   = idx[2:1];
  assign sel = idx[0];

  au_ref_model u_ref (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (expected)
  );

  assign sample   = (state == ST_DRIVE) && (cnt == HOLD_LAST);
  assign mismatch = sample && (y != expected);
  assign last_vec = (idx == 5'd31) || (mismatch && (STOP_ON_FAIL != 0));
  assign err_next = mismatch ? err_count + 6'd1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_DRIVE;
          start_acc  = 1'b1;
        end
      end
      ST_DRIVE: begin
        busy = 1'b1;
        if (sample && last_vec) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = ST_DRIVE;
          start_acc  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else if (start_acc) begin
      idx            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else if (state == ST_DRIVE) begin
      if (sample) begin
        err_count <= err_next;
        if (mismatch && !fail_seen) begin
          first_fail_idx <= idx;
          fail_seen      <= 1'b1;
        end
        // On the final vector idx stays put so the last operands remain on the bus.
        if (last_vec) begin
          pass <= (err_next == 6'd0);
        end else begin
          idx <= idx + 5'd1;
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_au_sweep_checker.sv
// tb/tb_au_sweep_checker.sv - self-checking bench: directed table, random fault masks, held start, async reset
module tb_au_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  int         fault_kind;
  logic [31:0] bad_mask;

  logic [3:0] y_m, y_s;
  logic [1:0] a_m, b_m, a_s, b_s;
  logic       sel_m, sel_s, busy_m, busy_s, done_m, done_s, pass_m, pass_s;
  logic       fs_m, fs_s;
  logic [5:0] err_m, err_s;
  logic [4:0] ffi_m, ffi_s;

  int n_pass, n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  au_sweep_checker #(.HOLD_CYCLES(4), .STOP_ON_FAIL(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_m),
    .a(a_m), .b(b_m), .sel(sel_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(err_m), .fail_seen(fs_m), .first_fail_idx(ffi_m)
  );

  au_sweep_checker #(.HOLD_CYCLES(4), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y_s),
    .a(a_s), .b(b_s), .sel(sel_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_seen(fs_s), .first_fail_idx(ffi_s)
  );

  // Behavioural arithmetic unit: kind 0 healthy, 1 y[0] stuck at 0, 2 inverted y on masked vectors.
  function automatic logic [3:0] unit_y(input int av, input int bv, input int sv,
                                        input int kind, input logic [31:0] mask);
    int r;
    logic [3:0] yy;
    r  = (sv != 0) ? av * bv : av + bv;
    yy = 4'(r);
    if (kind == 1) yy[0] = 1'b0;
    if (kind == 2 && mask[av * 8 + bv * 2 + sv]) yy = ~yy;
    return yy;
  endfunction

  always_comb y_m = unit_y(int'(a_m), int'(b_m), int'(sel_m), fault_kind, bad_mask);
  always_comb y_s = unit_y(int'(a_s), int'(b_s), int'(sel_s), fault_kind, bad_mask);

  // Whole-sweep expectation: walk the 32 vectors in order and count disagreements.
  task automatic sweep_model(input int kind, input logic [31:0] mask,
                             output int err, output int first);
    err = 0;
    first = 0;
    for (int i = 0; i < 32; i++) begin
      int av, bv, sv;
      av = i / 8;
      bv = (i / 2) % 4;
      sv = i % 2;
      if (unit_y(av, bv, sv, kind, mask) != unit_y(av, bv, sv, 0, 32'h0)) begin
        if (err == 0) first = i;
        err++;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs_m"}, int'({a_m, b_m, sel_m, busy_m, done_m, pass_m, err_m, fs_m, ffi_m}), 0);
    check({tag, "_outs_s"}, int'({a_s, b_s, sel_s, busy_s, done_s, pass_s, err_s, fs_s, ffi_s}), 0);
  endtask

  task automatic run_sweep(output int cm, output int cs);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy_m), 1);
    check("vec0_after_start", int'({a_m, b_m, sel_m}), 0);
    cm = -1;
    cs = -1;
    for (int c = 1; c <= 300 && (cm < 0 || cs < 0); c++) begin
      @(posedge clk);
      #1;
      if (done_m && cm < 0) cm = c;
      if (done_s && cs < 0) cs = c;
    end
  endtask

  task automatic check_sweep(input string tag, input int cm, input int cs,
                             input int e_err, input int e_first);
    int s_cyc, s_vec;
    s_cyc = (e_err > 0) ? (e_first + 1) * 4 : 128;
    s_vec = (e_err > 0) ? e_first : 31;
    check({tag, "_cycles_m"}, cm, 128);
    check({tag, "_err_m"}, int'(err_m), e_err);
    check({tag, "_first_m"}, int'(ffi_m), e_first);
    check({tag, "_pass_m"}, int'(pass_m), (e_err == 0) ? 1 : 0);
    check({tag, "_failseen_m"}, int'(fs_m), (e_err > 0) ? 1 : 0);
    check({tag, "_busy_m"}, int'(busy_m), 0);
    check({tag, "_lastvec_m"}, int'({a_m, b_m, sel_m}), 31);
    check({tag, "_cycles_s"}, cs, s_cyc);
    check({tag, "_err_s"}, int'(err_s), (e_err > 0) ? 1 : 0);
    check({tag, "_first_s"}, int'(ffi_s), e_first);
    check({tag, "_vec_s"}, int'({a_s, b_s, sel_s}), s_vec);
    check({tag, "_pass_s"}, int'(pass_s), (e_err == 0) ? 1 : 0);
  endtask

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] mask;
    int          exp_err;
    int          exp_first;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int cm, cs, e_err, e_first, cyc;

    n_pass = 0;
    n_total = 0;
    start = 1'b0;
    fault_kind = 0;
    bad_mask = '0;
    rst_n = 1'b0;

    tbl[0] = '{"golden",    0, 32'h0000_0000, 0,  0};
    tbl[1] = '{"y0_stuck0", 1, 32'h0000_0000, 12, 2};
    tbl[2] = '{"idx31",     2, 32'h8000_0000, 1,  31};
    tbl[3] = '{"idx0",      2, 32'h0000_0001, 1,  0};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start_busy", int'(busy_m), 0);

    foreach (tbl[i]) begin
      fault_kind = tbl[i].kind;
      bad_mask   = tbl[i].mask;
      run_sweep(cm, cs);
      check_sweep(tbl[i].name, cm, cs, tbl[i].exp_err, tbl[i].exp_first);
    end

    for (int r = 0; r < 6; r++) begin
      fault_kind = 2;
      bad_mask   = (r == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      sweep_model(fault_kind, bad_mask, e_err, e_first);
      run_sweep(cm, cs);
      check_sweep($sformatf("rand%0d", r), cm, cs, e_err, e_first);
    end

    // start held high: no restart while busy, immediate restart once DONE
    fault_kind = 1;
    bad_mask   = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = -1;
    for (int c = 1; c <= 300 && cyc < 0; c++) begin
      @(posedge clk);
      #1;
      if (done_m) cyc = c;
    end
    check("held_cycles_m", cyc, 128);
    check("held_err_m", int'(err_m), 12);
    @(posedge clk);
    #1;
    check("held_restart_busy", int'(busy_m), 1);
    check("held_restart_done", int'(done_m), 0);
    check("held_restart_err", int'(err_m), 0);
    check("held_restart_pass", int'(pass_m), 0);
    start = 1'b0;

    // asynchronous reset 50 cycles into a sweep
    fault_kind = 1;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle_busy", int'(busy_m), 0);
    check("post_reset_idle_done", int'(done_m), 0);
    fault_kind = 0;
    run_sweep(cm, cs);
    check_sweep("after_reset", cm, cs, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
